// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with per-frame snapshot,
// blanking gap at the start of every digit slot, and leading-zero suppression.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int DIGIT_HZ     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic                          blank_lz,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);

  localparam int DWELL = CLK_FREQ / DIGIT_HZ;
  localparam int CW    = $clog2(DWELL);
  localparam int IW    = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  logic [4*NUM_DIGITS-1:0] snap_d, snap_d_n;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic                    fs_n;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    run;
  logic                    dark;
  logic [3:0]              cur;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h01;
      4'h1: decode = 7'h4F;
      4'h2: decode = 7'h12;
      4'h3: decode = 7'h06;
      4'h4: decode = 7'h4C;
      4'h5: decode = 7'h24;
      4'h6: decode = 7'h20;
      4'h7: decode = 7'h0F;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h04;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h60;
      4'hC: decode = 7'h31;
      4'hD: decode = 7'h42;
      4'hE: decode = 7'h30;
      default: decode = 7'h38;
    endcase
  endfunction

  // Outputs are computed from the next-state values so they line up with
  // the state registers updated on the same edge.
  always_comb begin
    cnt_n     = cnt;
    idx_n     = idx;
    snap_d_n  = snap_d;
    snap_dp_n = snap_dp;
    fs_n      = 1'b0;
    an_n      = '1;
    seg_n     = 7'h7F;
    dp_n      = 1'b1;

    if (en) begin
      if (cnt == CNT_MAX) begin
        cnt_n = '0;
        if (idx == IDX_MAX) begin
          idx_n     = '0;
          snap_d_n  = digits;
          snap_dp_n = dp_mask;
          fs_n      = 1'b1;
        end else begin
          idx_n = idx + IW'(1);
        end
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end

    // lz[i]: snapshot digits i..top are all zero
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run   = run & (snap_d_n[4*i +: 4] == 4'h0);
      lz[i] = run;
    end
    dark = blank_lz && (idx_n != '0) && lz[idx_n];
    cur  = snap_d_n[4*int'(idx_n) +: 4];

    if (en && (cnt_n >= BLANK_C) && !dark) begin
      an_n[idx_n] = 1'b0;
      seg_n       = decode(cur);
      dp_n        = ~snap_dp_n[idx_n];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= CNT_MAX;
      idx         <= IDX_MAX;
      snap_d      <= '0;
      snap_dp     <= '0;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      an          <= '1;
      digit_idx   <= IDX_MAX;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      idx         <= idx_n;
      snap_d      <= snap_d_n;
      snap_dp     <= snap_dp_n;
      seg         <= seg_n;
      dp          <= dp_n;
      an          <= an_n;
      digit_idx   <= idx_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner (DWELL=8, BLANK_CYCLES=2).
module tb_seven_seg_scanner;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_start;

  int total = 0;
  int bad   = 0;

  seven_seg_scanner #(
    .NUM_DIGITS(4), .CLK_FREQ(16), .DIGIT_HZ(2), .BLANK_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .digits(digits), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .digit_idx(digit_idx),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [14:0] obs, exp_v;
    reset = 1'b0; en = 1'b1; digits = 16'h1234; dp_mask = 4'b0000; blank_lz = 1'b0;
    repeat (3) tick();
    obs   = {frame_start, an, seg, dp, digit_idx};
    exp_v = {1'b0, 4'hF, 7'h7F, 1'b1, 2'd3};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", obs, exp_v);
    end
  endtask

  // Releases reset and checks the first two slots of a 1234 frame.
  task automatic test_scan();
    logic [14:0] obs, exp_v;
    logic [3:0]  m;
    int slot, c;
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      slot = (e - 1) / 8;
      c    = (e - 1) % 8;
      m    = 4'b0001 << slot;
      exp_v = {(e == 1), 4'hF, 7'h7F, 1'b1, 2'(slot)};
      if (c >= 2) exp_v = {1'b0, ~m, (slot == 0) ? 7'h4C : 7'h06, 1'b1, 2'(slot)};
      obs = {frame_start, an, seg, dp, digit_idx};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL scan edge=%0d got=%h want=%h", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_no_tear();
    logic [14:0] obs, exp_v;
    logic [3:0]  m;
    logic [6:0]  s;
    int slot, c;
    digits = 16'h1234; dp_mask = 4'b0000; blank_lz = 1'b0; en = 1'b1;
    restart();
    for (int e = 1; e <= 35; e++) begin
      tick();
      slot = ((e - 1) / 8) % 4;
      c    = (e - 1) % 8;
      m    = 4'b0001 << slot;
      case (slot)
        0: s = (e > 32) ? 7'h38 : 7'h4C;
        1: s = 7'h06;
        2: s = 7'h12;
        default: s = 7'h4F;
      endcase
      exp_v = {(e == 1 || e == 33), 4'hF, 7'h7F, 1'b1, 2'(slot)};
      if (c >= 2) exp_v = {1'b0, ~m, s, 1'b1, 2'(slot)};
      obs = {frame_start, an, seg, dp, digit_idx};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL no_tear edge=%0d got=%h want=%h", e, obs, exp_v);
      end
      if (e == 12) digits = 16'hFFFF;
    end
  endtask

  task automatic test_lz();
    logic [14:0] obs, exp_v;
    logic [3:0]  m;
    logic [6:0]  s;
    logic        lit;
    int slot, c;
    digits = 16'h0050; dp_mask = 4'b0000; blank_lz = 1'b1; en = 1'b1;
    restart();
    for (int e = 1; e <= 64; e++) begin
      tick();
      slot = ((e - 1) / 8) % 4;
      c    = (e - 1) % 8;
      m    = 4'b0001 << slot;
      s    = (slot == 1) ? 7'h24 : 7'h01;
      lit  = (c >= 2) && (e > 32 || slot < 2);
      exp_v = {(e == 1 || e == 33), 4'hF, 7'h7F, 1'b1, 2'(slot)};
      if (lit) exp_v = {1'b0, ~m, s, 1'b1, 2'(slot)};
      obs = {frame_start, an, seg, dp, digit_idx};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL lz edge=%0d blank_lz=%0b got=%h want=%h", e, blank_lz, obs, exp_v);
      end
      if (e == 32) blank_lz = 1'b0;
    end
  endtask

  task automatic test_dp();
    logic [14:0] obs, exp_v;
    logic [3:0]  m;
    logic [6:0]  s;
    int slot, c;
    digits = 16'h1234; dp_mask = 4'b0100; blank_lz = 1'b0; en = 1'b1;
    restart();
    for (int e = 1; e <= 32; e++) begin
      tick();
      slot = (e - 1) / 8;
      c    = (e - 1) % 8;
      m    = 4'b0001 << slot;
      case (slot)
        0: s = 7'h4C;
        1: s = 7'h06;
        2: s = 7'h12;
        default: s = 7'h4F;
      endcase
      exp_v = {(e == 1), 4'hF, 7'h7F, 1'b1, 2'(slot)};
      if (c >= 2) exp_v = {1'b0, ~m, s, (slot != 2), 2'(slot)};
      obs = {frame_start, an, seg, dp, digit_idx};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL dp edge=%0d got=%h want=%h", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_freeze();
    logic [14:0] obs, exp_v;
    int on_cnt, slot_len;
    logic done;
    digits = 16'h1234; dp_mask = 4'b0000; blank_lz = 1'b0; en = 1'b1;
    restart();
    on_cnt = 0; slot_len = 0;
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (digit_idx == 2'd1) slot_len++;
      if (an == 4'b1101) on_cnt++;
    end
    en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      obs   = {frame_start, an, seg, dp, digit_idx};
      exp_v = {1'b0, 4'hF, 7'h7F, 1'b1, 2'd1};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL freeze_hold cycle=%0d got=%h want=%h", k, obs, exp_v);
      end
    end
    en = 1'b1;
    tick();
    total++;
    if (an !== 4'b1101) begin
      bad++;
      $display("FAIL freeze_resume an got=%b want=1101", an);
    end
    if (digit_idx == 2'd1) slot_len++;
    if (an == 4'b1101) on_cnt++;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (digit_idx != 2'd1) done = 1'b1;
      else begin
        slot_len++;
        if (an == 4'b1101) on_cnt++;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL freeze_timeout digit_idx got=%0d want=2", digit_idx);
    end
    total++;
    if (on_cnt !== 6) begin
      bad++;
      $display("FAIL freeze_on_cycles got=%0d want=6", on_cnt);
    end
    total++;
    if (slot_len !== 8) begin
      bad++;
      $display("FAIL freeze_slot_len got=%0d want=8", slot_len);
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] obs, exp_v;
    digits = 16'h1234; dp_mask = 4'b0000; blank_lz = 1'b0; en = 1'b1;
    restart();
    repeat (20) tick();
    total++;
    if (an !== 4'b1011) begin
      bad++;
      $display("FAIL mid_pre an got=%b want=1011", an);
    end
    #2;
    reset = 1'b0;
    #1;
    obs   = {frame_start, an, seg, dp, digit_idx};
    exp_v = {1'b0, 4'hF, 7'h7F, 1'b1, 2'd3};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL mid_reset_async got=%h want=%h", obs, exp_v);
    end
    test_scan();
  endtask

  initial begin
    test_reset();
    test_scan();
    test_no_tear();
    test_lz();
    test_dp();
    test_freeze();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
